spi_cmd_sequencer: RTL and testbench

SPI_CMD_SEQUENCER -- requirements
Module: spi_cmd_sequencer

---
 rtl/actuator_pkg.sv | 44 ++++
 rtl/cmd_shadow_regs.sv | 28 ++
 rtl/spi_cmd_sequencer.sv | 165 ++++++++++++++++
 tb/tb_spi_cmd_sequencer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/actuator_pkg.sv
// Shared definitions for the SPI command sequencer: opcodes, FSM encoding,
// frame field layout and error-flag bit positions.
package actuator_pkg;

  localparam int NUM_REGS_DEF = 8;

  // Frame layout: [31:28] opcode, [27:24] reserved, [23:16] addr, [15:0] data
  localparam int OP_LSB   = 28;
  localparam int ADDR_LSB = 16;
  localparam int DATA_LSB = 0;

  localparam logic [3:0] OP_NOP    = 4'h0;
  localparam logic [3:0] OP_WRITE  = 4'h1;
  localparam logic [3:0] OP_READ   = 4'h2;
  localparam logic [3:0] OP_COMMIT = 4'h3;
  localparam logic [3:0] OP_ARM    = 4'h4;
  localparam logic [3:0] OP_ABORT  = 4'h5;
  localparam logic [3:0] OP_CLRERR = 4'h6;

  // err_flags = {illegal_op, addr_range, overrun}
  localparam int ERR_ILL  = 2;
  localparam int ERR_ADDR = 1;
  localparam int ERR_OVR  = 0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_ARMED  = 2'd3
  } state_e;

  function automatic logic [3:0] f_op(input logic [31:0] f);
    return f[OP_LSB +: 4];
  endfunction

  function automatic logic [7:0] f_addr(input logic [31:0] f);
    return f[ADDR_LSB +: 8];
  endfunction

  function automatic logic [15:0] f_data(input logic [31:0] f);
    return f[DATA_LSB +: 16];
  endfunction

endpackage

// File: rtl/cmd_shadow_regs.sv
// Shadow configuration registers: one write port, one combinational read
// port, and the whole array exposed for bulk commit into the active set.
module cmd_shadow_regs #(
  parameter  int NUM_REGS = 8,
  localparam int AW       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                      gclk,
  input  logic                      grst_n,
  input  logic                      we_i,
  input  logic [AW-1:0]             waddr_i,
  input  logic [15:0]               wdata_i,
  input  logic [AW-1:0]             raddr_i,
  output logic [15:0]               rdata_o,
  output logic [NUM_REGS-1:0][15:0] bulk_o
);

  logic [NUM_REGS-1:0][15:0] regs_q;

  // Register array; a single entry is written per cycle
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n)   regs_q          <= '0;
    else if (we_i) regs_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = regs_q[raddr_i];
  assign bulk_o  = regs_q;

endmodule

// File: rtl/spi_cmd_sequencer.sv
// Decodes SPI command frames, maintains shadow/active actuator config,
// and sequences the arm/trigger handshake that starts the actuator drive.
module spi_cmd_sequencer
  import actuator_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    enable_n,
  input  logic                    frame_valid,
  input  logic [31:0]             frame_data,
  input  logic                    latch_req,
  input  logic                    trigger_req,
  output logic [31:0]             tx_data,
  output logic                    tx_load,
  output logic [16*NUM_REGS-1:0]  active_cfg,
  output logic                    drive_start,
  output logic                    armed,
  output logic [2:0]              err_flags
);

  localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  state_e                    state_q, state_d;
  logic [31:0]               frame_q, frame_d;
  logic [31:0]               tx_data_q, tx_data_d;
  logic                      tx_load_q, tx_load_d;
  logic                      drive_q, drive_d;
  logic [2:0]                err_q, err_d, err_new;
  logic                      pend_q, pend_d;
  logic [NUM_REGS-1:0][15:0] cfg_q, cfg_d;
  logic [NUM_REGS-1:0][15:0] shadow;
  logic [15:0]               rdata;
  logic                      we, commit, clr;

  logic [3:0]  op;
  logic [7:0]  addr;
  logic        addr_ok, is_rw;

  assign op      = f_op(frame_q);
  assign addr    = f_addr(frame_q);
  assign addr_ok = ({24'd0, addr} < 32'(NUM_REGS));
  assign is_rw   = (op == OP_WRITE) || (op == OP_READ);

  cmd_shadow_regs #(.NUM_REGS(NUM_REGS)) u_shadow (
    .gclk    (clock),
    .grst_n  (reset_n),
    .we_i    (we),
    .waddr_i (addr[AW-1:0]),
    .wdata_i (f_data(frame_q)),
    .raddr_i (addr[AW-1:0]),
    .rdata_o (rdata),
    .bulk_o  (shadow)
  );

  // State and output registers; outputs are registered so they hold cleanly
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      frame_q   <= '0;
      tx_data_q <= '0;
      tx_load_q <= 1'b0;
      drive_q   <= 1'b0;
      err_q     <= '0;
      pend_q    <= 1'b0;
      cfg_q     <= '0;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      tx_data_q <= tx_data_d;
      tx_load_q <= tx_load_d;
      drive_q   <= drive_d;
      err_q     <= err_d;
      pend_q    <= pend_d;
      cfg_q     <= cfg_d;
    end
  end

  // Next-state, response and side-effect decode. The response word is built
  // in DECODE so tx_data/tx_load are valid for exactly the EXEC cycle.
  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    tx_data_d = tx_data_q;
    tx_load_d = 1'b0;
    drive_d   = 1'b0;
    pend_d    = pend_q;
    err_new   = '0;
    we        = 1'b0;
    commit    = 1'b0;
    clr       = 1'b0;

    if (enable_n) begin
      state_d = ST_IDLE;
      pend_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (frame_valid) begin
            frame_d = frame_data;
            state_d = ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (frame_valid) err_new[ERR_OVR] = 1'b1;
          tx_load_d = 1'b1;
          tx_data_d = frame_q;
          if (op == OP_READ) tx_data_d = {op, 4'h0, addr, rdata};
          if (is_rw && !addr_ok) tx_data_d[15:0] = 16'h0000;
          state_d = ST_EXEC;
        end
        ST_EXEC: begin
          if (frame_valid) err_new[ERR_OVR] = 1'b1;
          state_d = (op == OP_ARM) ? ST_ARMED : ST_IDLE;
          case (op)
            OP_WRITE:         if (addr_ok) we = 1'b1; else err_new[ERR_ADDR] = 1'b1;
            OP_READ:          if (!addr_ok) err_new[ERR_ADDR] = 1'b1;
            OP_COMMIT, OP_ARM: commit = 1'b1;
            OP_CLRERR:        clr = 1'b1;
            OP_NOP, OP_ABORT: ;
            default:          err_new[ERR_ILL] = 1'b1;
          endcase
        end
        ST_ARMED: begin
          // Trigger has priority over any coincident frame
          if (trigger_req) begin
            drive_d = 1'b1;
            state_d = ST_IDLE;
            if (frame_valid) err_new[ERR_OVR] = 1'b1;
          end else if (frame_valid) begin
            if (f_op(frame_data) == OP_ABORT) begin
              state_d   = ST_IDLE;
              tx_load_d = 1'b1;
              tx_data_d = frame_data;
              frame_d   = frame_data;
            end else begin
              err_new[ERR_OVR] = 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase

      // External latch: one pending request, applied in IDLE or ARMED
      if ((state_q == ST_IDLE || state_q == ST_ARMED) && (pend_q || latch_req)) begin
        commit = 1'b1;
        pend_d = 1'b0;
      end else if (latch_req) begin
        pend_d = 1'b1;
      end
    end

    err_d = (clr ? 3'b000 : err_q) | err_new;
    cfg_d = commit ? shadow : cfg_q;
  end

  assign tx_data     = tx_data_q;
  assign tx_load     = tx_load_q;
  assign active_cfg  = cfg_q;
  assign drive_start = drive_q;
  assign armed       = (state_q == ST_ARMED);
  assign err_flags   = err_q;

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Directed bench: frame vector table plus hand-built multi-cycle sequences.
module tb_spi_cmd_sequencer;

  localparam int NR = 8;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              enable_n;
  logic              frame_valid;
  logic [31:0]       frame_data;
  logic              latch_req;
  logic              trigger_req;
  logic [31:0]       tx_data;
  logic              tx_load;
  logic [16*NR-1:0]  active_cfg;
  logic              drive_start;
  logic              armed;
  logic [2:0]        err_flags;

  int n_vec = 0;
  int n_err = 0;
  int pulses;

  typedef struct {
    logic [31:0] frame;
    logic [31:0] exp_tx;
    logic [2:0]  exp_err;
    int          cfg_idx;
    logic [15:0] exp_cfg;
  } vec_t;

  vec_t vecs [0:15];

  spi_cmd_sequencer #(.NUM_REGS(NR)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .enable_n    (enable_n),
    .frame_valid (frame_valid),
    .frame_data  (frame_data),
    .latch_req   (latch_req),
    .trigger_req (trigger_req),
    .tx_data     (tx_data),
    .tx_load     (tx_load),
    .active_cfg  (active_cfg),
    .drive_start (drive_start),
    .armed       (armed),
    .err_flags   (err_flags)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] cfg(input int i);
    return active_cfg[16*i +: 16];
  endfunction

  task automatic send(input logic [31:0] f);
    frame_valid = 1'b1;
    frame_data  = f;
    tick();
    frame_valid = 1'b0;
  endtask

  // Full frame: returns after the EXEC edge (IDLE, or ARMED for ARM)
  task automatic run_frame(input logic [31:0] f);
    send(f);
    tick();
    tick();
  endtask

  initial begin
    vecs[0]  = '{32'h1003BEEF, 32'h1003BEEF, 3'b000, 3, 16'h0000};
    vecs[1]  = '{32'h20030000, 32'h2003BEEF, 3'b000, 3, 16'h0000};
    vecs[2]  = '{32'h1003FACE, 32'h1003FACE, 3'b000, 3, 16'h0000};
    vecs[3]  = '{32'h30000000, 32'h30000000, 3'b000, 3, 16'hFACE};
    vecs[4]  = '{32'h10051234, 32'h10051234, 3'b000, 5, 16'h0000};
    vecs[5]  = '{32'h20050000, 32'h20051234, 3'b000, 5, 16'h0000};
    vecs[6]  = '{32'h20090000, 32'h20090000, 3'b010, 3, 16'hFACE};
    vecs[7]  = '{32'h60000000, 32'h60000000, 3'b000, 3, 16'hFACE};
    vecs[8]  = '{32'h1008AAAA, 32'h10080000, 3'b010, 0, 16'h0000};
    vecs[9]  = '{32'h200B0000, 32'h200B0000, 3'b010, 3, 16'hFACE};
    vecs[10] = '{32'h9ABC1234, 32'h9ABC1234, 3'b110, 5, 16'h0000};
    vecs[11] = '{32'h6FFFFFFF, 32'h6FFFFFFF, 3'b000, 5, 16'h0000};
    vecs[12] = '{32'h00123456, 32'h00123456, 3'b000, 5, 16'h0000};
    vecs[13] = '{32'h2F031111, 32'h2003FACE, 3'b000, 3, 16'hFACE};
    vecs[14] = '{32'h30000000, 32'h30000000, 3'b000, 5, 16'h1234};
    vecs[15] = '{32'h20000000, 32'h20000000, 3'b000, 0, 16'h0000};

    reset_n = 1'b0; enable_n = 1'b0; frame_valid = 1'b0; frame_data = '0;
    latch_req = 1'b0; trigger_req = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    chk("rst_tx_data", tx_data, 0);
    chk("rst_tx_load", 32'(tx_load), 0);
    chk("rst_cfg", 32'(active_cfg != '0), 0);
    chk("rst_err", 32'(err_flags), 0);
    chk("rst_armed", 32'(armed), 0);
    chk("rst_drive", 32'(drive_start), 0);

    // Table: each frame checked in EXEC (response) and after EXEC (effects)
    for (int i = 0; i < 16; i++) begin
      send(vecs[i].frame);
      tick();
      chk($sformatf("v%0d_tx_load", i), 32'(tx_load), 1);
      chk($sformatf("v%0d_tx_data", i), tx_data, vecs[i].exp_tx);
      tick();
      chk($sformatf("v%0d_tx_load_off", i), 32'(tx_load), 0);
      chk($sformatf("v%0d_err", i), 32'(err_flags), 32'(vecs[i].exp_err));
      chk($sformatf("v%0d_cfg", i), 32'(cfg(vecs[i].cfg_idx)), 32'(vecs[i].exp_cfg));
    end

    // Back-to-back frames: second dropped, one tx_load, overrun set
    frame_valid = 1'b1; frame_data = 32'h10011111;
    tick();
    frame_data = 32'h10012222;
    tick();
    frame_valid = 1'b0;
    pulses = int'(tx_load);
    for (int k = 0; k < 5; k++) begin tick(); pulses += int'(tx_load); end
    chk("ovr_txload_cnt", 32'(pulses), 1);
    chk("ovr_err", 32'(err_flags), 3'b001);
    send(32'h20010000); tick();
    chk("ovr_first_kept", tx_data, 32'h20011111);
    tick();
    run_frame(32'h60000000);
    chk("ovr_clr", 32'(err_flags), 0);

    // latch_req in IDLE copies immediately; during a frame it waits for IDLE
    run_frame(32'h10022222);
    chk("latch_pre", 32'(cfg(2)), 0);
    latch_req = 1'b1; tick(); latch_req = 1'b0;
    chk("latch_idle", 32'(cfg(2)), 32'h2222);
    run_frame(32'h10023333);
    send(32'h00000000);
    latch_req = 1'b1; tick(); latch_req = 1'b0;
    tick();
    chk("latch_held", 32'(cfg(2)), 32'h2222);
    tick();
    chk("latch_pending", 32'(cfg(2)), 32'h3333);

    // ARM then trigger after 20 cycles
    run_frame(32'h1000A5A5);
    run_frame(32'h40000000);
    chk("arm_armed", 32'(armed), 1);
    chk("arm_commit", 32'(cfg(0)), 32'hA5A5);
    pulses = 0;
    for (int k = 0; k < 20; k++) begin tick(); pulses += int'(drive_start); end
    chk("arm_no_early_drive", 32'(pulses), 0);
    chk("arm_still", 32'(armed), 1);
    trigger_req = 1'b1; tick(); trigger_req = 1'b0;
    chk("trig_drive", 32'(drive_start), 1);
    chk("trig_disarm", 32'(armed), 0);
    tick();
    chk("trig_single", 32'(drive_start), 0);
    trigger_req = 1'b1; tick(); trigger_req = 1'b0; tick();
    chk("trig_idle_ignored", 32'(drive_start), 0);

    // ABORT while armed: echo next cycle, no drive
    run_frame(32'h40000000);
    send(32'h50000000);
    chk("abort_txload", 32'(tx_load), 1);
    chk("abort_echo", tx_data, 32'h50000000);
    chk("abort_disarm", 32'(armed), 0);
    trigger_req = 1'b1; tick(); trigger_req = 1'b0; tick();
    chk("abort_no_drive", 32'(drive_start), 0);

    // Armed: other frame overruns; trigger beats a coincident frame
    run_frame(32'h40000000);
    send(32'h10047777);
    chk("armed_drop_load", 32'(tx_load), 0);
    chk("armed_drop_ovr", 32'(err_flags), 3'b001);
    chk("armed_drop_stay", 32'(armed), 1);
    frame_valid = 1'b1; frame_data = 32'h50000000; trigger_req = 1'b1;
    tick();
    frame_valid = 1'b0; trigger_req = 1'b0;
    chk("coinc_drive", 32'(drive_start), 1);
    chk("coinc_txload", 32'(tx_load), 0);
    tick();
    run_frame(32'h60000000);

    // enable_n high while armed: to IDLE, state retained, strobes ignored
    run_frame(32'h20090000);
    run_frame(32'h40000000);
    enable_n = 1'b1; tick();
    chk("en_disarm", 32'(armed), 0);
    trigger_req = 1'b1; tick(); trigger_req = 1'b0; tick();
    chk("en_trig_ignored", 32'(drive_start), 0);
    enable_n = 1'b0;
    trigger_req = 1'b1; tick(); trigger_req = 1'b0; tick();
    chk("en_trig_after", 32'(drive_start), 0);
    chk("en_err_kept", 32'(err_flags), 3'b010);
    chk("en_cfg_kept", 32'(cfg(0)), 32'hA5A5);

    // Asynchronous reset in EXEC, then frame accepted on first edge after
    send(32'h20030000); tick();
    chk("pre_rst_load", 32'(tx_load), 1);
    reset_n = 1'b0; #1;
    chk("arst_tx_load", 32'(tx_load), 0);
    chk("arst_tx_data", tx_data, 0);
    chk("arst_cfg", 32'(active_cfg != '0), 0);
    chk("arst_err", 32'(err_flags), 0);
    tick();
    reset_n = 1'b1;
    send(32'h20030000); tick();
    chk("post_rst_load", 32'(tx_load), 1);
    chk("post_rst_shadow", tx_data, 32'h20030000);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
